// File: rtl/mb_drive_responder_if.sv
// Massbus slave-side bus bundle between the RH11 controller and one drive.
// master = controller side, slave = drive side; clk/rst are separate ports.
interface mb_drive_responder_if;
  logic        mbINIT;
  logic        mbREAD;
  logic        mbWRITE;
  logic [4:0]  mbREGSEL;
  logic [2:0]  mbUNIT;
  logic [4:0]  mbFUN;
  logic        mbGO;
  logic [0:35] mbDATAI;
  logic        mbACKI;
  logic        mbWCZ;
  logic [15:0] mbREGDAT;
  logic        mbREGACK;
  logic [0:35] mbDATAO;
  logic        mbREQO;
  logic        mbINCBA;
  logic        mbINCWC;
  logic        mbNPRO;
  logic [7:0]  mbATA;
  logic        mbDVA;
  logic        mbDPR;
  logic        mbDRY;
  logic        mbACLO;
  logic        mbCPE;
  logic        mbDPE;
  logic        mbDECBA;
  logic        mbWCE;

  modport master (
    output mbINIT, mbREAD, mbWRITE, mbREGSEL, mbUNIT,
    output mbFUN, mbGO, mbDATAI, mbACKI, mbWCZ,
    input  mbREGDAT, mbREGACK, mbDATAO, mbREQO,
    input  mbINCBA, mbINCWC, mbNPRO, mbATA,
    input  mbDVA, mbDPR, mbDRY,
    input  mbACLO, mbCPE, mbDPE, mbDECBA, mbWCE
  );

  modport slave (
    input  mbINIT, mbREAD, mbWRITE, mbREGSEL, mbUNIT,
    input  mbFUN, mbGO, mbDATAI, mbACKI, mbWCZ,
    output mbREGDAT, mbREGACK, mbDATAO, mbREQO,
    output mbINCBA, mbINCWC, mbNPRO, mbATA,
    output mbDVA, mbDPR, mbDRY,
    output mbACLO, mbCPE, mbDPE, mbDECBA, mbWCE
  );
endinterface

// File: rtl/mb_drive_responder.sv
// Massbus drive responder: one disk unit answering register access, seeks
// and word-handshake transfers. Ports: clk, rst (async active-low), mb
// (slave modport). Optional CK checksum register: define MBDRV_CKSUM_EN.
module mb_drive_responder #(
  parameter int          UNIT     = 0,
  parameter logic [15:0] DRVTYPE  = 16'o020022,
  parameter int          SEEK_DLY = 64
) (
  input logic               clk,
  input logic               rst,
  mb_drive_responder_if.slave mb
);

  localparam int CW = $clog2(SEEK_DLY + 1);

  typedef enum logic [2:0] {
    IDLE, POS, XREQ, XACK, XCHK
  } state_t;

  state_t      state, state_nx;
  logic        dry, pip, ata, ilf, rmr;
  logic [15:0] da;
  logic [4:0]  fun_last;
  logic [17:0] widx;
  logic        is_wr;
  logic [CW-1:0] pos_cnt;
  logic        regack;
  logic [15:0] regdat;
  logic [15:0] rdat;

  logic        sel, rd, wr, go, go_ok, go_bad;
  logic        f_nop, f_seek, f_recal, f_clr;
  logic        f_write, f_read, f_ill;
  logic        xfer_done;
  logic [15:0] wd;

  assign sel    = (mb.mbUNIT == 3'(UNIT));
  assign rd     = mb.mbREAD & sel;
  assign wr     = mb.mbWRITE & sel;
  assign wd     = mb.mbDATAI[20:35];
  assign go     = wr & (mb.mbREGSEL == 5'd0) & mb.mbGO;
  assign go_ok  = go & dry;
  assign go_bad = go & ~dry;

  assign f_nop   = go_ok & (mb.mbFUN == 5'd0);
  assign f_seek  = go_ok & (mb.mbFUN == 5'd2);
  assign f_recal = go_ok & (mb.mbFUN == 5'd3);
  assign f_clr   = go_ok & (mb.mbFUN == 5'd4);
  assign f_write = go_ok & (mb.mbFUN == 5'd24);
  assign f_read  = go_ok & (mb.mbFUN == 5'd28);
  assign f_ill   = go_ok & ~(f_nop | f_seek | f_recal
                   | f_clr | f_write | f_read);

  assign xfer_done = (state == XCHK) & mb.mbWCZ;

`ifdef MBDRV_CKSUM_EN
  logic [15:0] ck;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ck <= '0;
    end else if (mb.mbINIT || f_write || f_clr) begin
      ck <= '0;
    end else if (state == XACK && is_wr) begin
      ck <= ck + wd;
    end
  end
`endif

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (f_seek || f_recal)
          state_nx = POS;
        else if (f_read || f_write)
          state_nx = XREQ;
      end
      POS:  if (pos_cnt == '0) state_nx = IDLE;
      XREQ: if (mb.mbACKI) state_nx = XACK;
      XACK: state_nx = XCHK;
      XCHK: state_nx = mb.mbWCZ ? IDLE : XREQ;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state <= IDLE;
    else if (mb.mbINIT)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    rdat = '0;
    unique case (mb.mbREGSEL)
      5'd0: rdat = {8'd0, dry, 1'b0, fun_last, 1'b0};
      5'd1: rdat = {ata, ilf | rmr, pip, 1'b1,
                    3'd0, 1'b1, dry, 7'd0};
      5'd2: rdat = {13'd0, rmr, 1'b0, ilf};
      5'd4: rdat[UNIT] = ata;
      5'd5: rdat = da;
      5'd6: rdat = DRVTYPE;
`ifdef MBDRV_CKSUM_EN
      5'd7: rdat = ck;
`endif
      default: rdat = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dry      <= 1'b1;
      pip      <= 1'b0;
      ata      <= 1'b0;
      ilf      <= 1'b0;
      rmr      <= 1'b0;
      da       <= '0;
      fun_last <= '0;
      widx     <= '0;
      is_wr    <= 1'b0;
      pos_cnt  <= '0;
      regack   <= 1'b0;
      regdat   <= '0;
    end else if (mb.mbINIT) begin
      dry      <= 1'b1;
      pip      <= 1'b0;
      ata      <= 1'b0;
      ilf      <= 1'b0;
      rmr      <= 1'b0;
      da       <= '0;
      fun_last <= '0;
      widx     <= '0;
      is_wr    <= 1'b0;
      pos_cnt  <= '0;
      regack   <= 1'b0;
      regdat   <= '0;
    end else begin
      // read data is sampled before any same-cycle write lands
      regack <= rd;
      regdat <= rd ? rdat : '0;
      if (go_bad) begin
        rmr <= 1'b1;
        ata <= 1'b1;
      end
      if (go_ok)
        fun_last <= mb.mbFUN;
      if (f_seek || f_recal) begin
        pip     <= 1'b1;
        dry     <= 1'b0;
        pos_cnt <= CW'(SEEK_DLY - 1);
      end
      if (f_recal)
        da <= '0;
      if (f_clr) begin
        ilf <= 1'b0;
        rmr <= 1'b0;
        ata <= 1'b0;
      end
      if (f_ill) begin
        ilf <= 1'b1;
        ata <= 1'b1;
      end
      if (f_read || f_write) begin
        dry   <= 1'b0;
        widx  <= '0;
        is_wr <= f_write;
      end
      if (state == POS) begin
        if (pos_cnt == '0) begin
          pip <= 1'b0;
          dry <= 1'b1;
          ata <= 1'b1;
        end else begin
          pos_cnt <= pos_cnt - 1'b1;
        end
      end
      if (state == XACK)
        widx <= widx + 1'b1;
      if (xfer_done)
        dry <= 1'b1;
      if (wr && mb.mbREGSEL == 5'd5) begin
        if (dry)
          da <= wd;
        else
          rmr <= 1'b1;
      end
      if (wr && mb.mbREGSEL == 5'd4 && wd[UNIT])
        ata <= 1'b0;
    end
  end

  assign mb.mbREGDAT = regdat;
  assign mb.mbREGACK = regack;
  assign mb.mbDATAO  = (state == XREQ && !is_wr)
                       ? {2'b00, da, widx} : '0;
  assign mb.mbREQO   = (state == XREQ);
  assign mb.mbINCBA  = (state == XACK);
  assign mb.mbINCWC  = (state == XACK);
  assign mb.mbNPRO   = (state == XREQ) || (state == XACK)
                       || (state == XCHK);
  assign mb.mbATA    = {7'd0, ata} << UNIT;
  assign mb.mbDVA    = 1'b1;
  assign mb.mbDPR    = sel;
  assign mb.mbDRY    = dry;
  assign mb.mbACLO   = 1'b0;
  assign mb.mbCPE    = 1'b0;
  assign mb.mbDPE    = 1'b0;
  assign mb.mbDECBA  = 1'b0;
  assign mb.mbWCE    = 1'b0;

endmodule

// File: tb/tb_mb_drive_responder.sv
// Directed + randomized bench for mb_drive_responder with a behavioural
// drive model; honours MBDRV_CKSUM_EN for the CK register.
module tb_mb_drive_responder;
  localparam int SEEK_DLY = 64;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mb_drive_responder_if bus();

  mb_drive_responder #(
    .UNIT(0),
    .DRVTYPE(16'o020022),
    .SEEK_DLY(SEEK_DLY)
  ) dut (
    .clk(clk),
    .rst(rst),
    .mb(bus)
  );

  int pass_n = 0;
  int total_n = 0;

  logic [15:0] m_da;
  logic [15:0] m_ck;
  logic [4:0]  m_fun;
  bit          m_ata, m_ilf, m_rmr, m_pip, m_dry;
  logic [15:0] wdat [8];

  task automatic check(input string tag,
                       input logic [35:0] obs,
                       input logic [35:0] exp);
    total_n++;
    assert (obs === exp) pass_n++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_da = 0; m_ck = 0; m_fun = 0;
    m_ata = 0; m_ilf = 0; m_rmr = 0; m_pip = 0; m_dry = 1;
  endtask

  function automatic logic [15:0] exp_ds();
    int v;
    v = 'o010400;
    if (m_ata) v += 'o100000;
    if (m_ilf || m_rmr) v += 'o040000;
    if (m_pip) v += 'o020000;
    if (m_dry) v += 'o000200;
    return 16'(v);
  endfunction

  function automatic logic [15:0] exp_er1();
    return 16'((m_rmr ? 4 : 0) + (m_ilf ? 1 : 0));
  endfunction

  function automatic logic [15:0] exp_ck();
`ifdef MBDRV_CKSUM_EN
    return m_ck;
`else
    return 16'd0;
`endif
  endfunction

  task automatic reg_wr(input logic [4:0] sel, input logic [15:0] d,
                        input logic go, input logic [4:0] fun);
    bus.mbUNIT   = 3'd0;
    bus.mbREGSEL = sel;
    bus.mbDATAI  = {20'd0, d};
    bus.mbGO     = go;
    bus.mbFUN    = fun;
    bus.mbWRITE  = 1'b1;
    tick();
    bus.mbWRITE  = 1'b0;
    bus.mbGO     = 1'b0;
  endtask

  task automatic reg_rd(input logic [4:0] sel, input logic [15:0] exp,
                        input string tag);
    bus.mbUNIT   = 3'd0;
    bus.mbREGSEL = sel;
    bus.mbREAD   = 1'b1;
    tick();
    bus.mbREAD   = 1'b0;
    check({tag, "_ack"}, 36'(bus.mbREGACK), 36'd1);
    check(tag, 36'(bus.mbREGDAT), 36'(exp));
    tick();
    check({tag, "_ack_drop"}, 36'(bus.mbREGACK), 36'd0);
  endtask

  task automatic model_go(input logic [4:0] fun);
    if (!m_dry) begin
      m_rmr = 1; m_ata = 1;
    end else begin
      m_fun = fun;
      case (fun)
        5'd0: ;
        5'd2: begin m_pip = 1; m_dry = 0; end
        5'd3: begin m_pip = 1; m_dry = 0; m_da = 0; end
        5'd4: begin m_ilf = 0; m_rmr = 0; m_ata = 0; m_ck = 0; end
        5'd24: begin m_dry = 0; m_ck = 0; end
        5'd28: m_dry = 0;
        default: begin m_ilf = 1; m_ata = 1; end
      endcase
    end
  endtask

  task automatic drv_go(input logic [4:0] fun);
    reg_wr(5'd0, 16'd0, 1'b1, fun);
    model_go(fun);
  endtask

  task automatic da_wr(input logic [15:0] v);
    reg_wr(5'd5, v, 1'b0, 5'd0);
    if (m_dry) m_da = v;
    else m_rmr = 1;
  endtask

  task automatic wait_seek(input bit chk_len, input string tag);
    int n = 0;
    while (bus.mbDRY !== 1'b1 && n < 500) begin
      tick();
      n++;
    end
    if (chk_len) check({tag, "_len"}, 36'(n), 36'(SEEK_DLY));
    else check({tag, "_done"}, 36'(bus.mbDRY), 36'd1);
    m_pip = 0; m_dry = 1; m_ata = 1;
    check({tag, "_ata"}, 36'(bus.mbATA), 36'(m_ata));
  endtask

  task automatic xfer(input bit w, input int n, input int ack_max,
                      input string tag);
    logic [35:0] word;
    drv_go(w ? 5'd24 : 5'd28);
    for (int i = 0; i < n; i++) begin
      int wt = 0;
      while (bus.mbREQO !== 1'b1 && wt < 20) begin
        tick();
        wt++;
      end
      check({tag, "_reqwait"}, 36'(wt), 36'd0);
      check({tag, "_npro"}, 36'(bus.mbNPRO), 36'd1);
      if (!w) begin
        word = (36'(m_da) << 18) + 36'(i);
        check({tag, "_data"}, bus.mbDATAO, word);
      end else begin
        bus.mbDATAI = {20'd0, wdat[i]};
      end
      repeat ($urandom_range(0, ack_max)) tick();
      bus.mbACKI = 1'b1;
      tick();
      bus.mbACKI = 1'b0;
      check({tag, "_incba"}, 36'(bus.mbINCBA), 36'd1);
      check({tag, "_incwc"}, 36'(bus.mbINCWC), 36'd1);
      check({tag, "_req_low"}, 36'(bus.mbREQO), 36'd0);
      if (w) m_ck = m_ck + wdat[i];
      bus.mbWCZ = (i == n - 1);
      tick();
      check({tag, "_inc_pulse"}, 36'(bus.mbINCBA), 36'd0);
      tick();
      bus.mbWCZ = 1'b0;
    end
    m_dry = 1;
    check({tag, "_dry"}, 36'(bus.mbDRY), 36'd1);
    check({tag, "_npro_end"}, 36'(bus.mbNPRO), 36'd0);
    check({tag, "_ata_end"}, 36'(bus.mbATA), 36'(m_ata));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] v, old;
    int nw;
    bus.mbINIT = 0; bus.mbREAD = 0; bus.mbWRITE = 0;
    bus.mbREGSEL = 0; bus.mbUNIT = 0; bus.mbFUN = 0; bus.mbGO = 0;
    bus.mbDATAI = '0; bus.mbACKI = 0; bus.mbWCZ = 0;
    model_reset();
    repeat (3) tick();
    rst = 1'b1;
    tick();

    check("rst_dry", 36'(bus.mbDRY), 36'd1);
    check("rst_ata", 36'(bus.mbATA), 36'd0);
    check("rst_reqo", 36'(bus.mbREQO), 36'd0);
    check("rst_npro", 36'(bus.mbNPRO), 36'd0);
    check("rst_regack", 36'(bus.mbREGACK), 36'd0);
    check("rst_datao", bus.mbDATAO, 36'd0);
    check("rst_dva", 36'(bus.mbDVA), 36'd1);
    reg_rd(5'd1, 16'o010600, "ds_reset");
    reg_rd(5'd6, 16'o020022, "dt");
    reg_wr(5'd3, 16'hbeef, 1'b0, 5'd0);
    reg_rd(5'd3, 16'd0, "reg03");

    v = 16'($urandom);
    da_wr(v);
    reg_rd(5'd5, m_da, "da_rand");
    old = m_da;
    v = 16'($urandom);
    bus.mbREGSEL = 5'd5;
    bus.mbDATAI  = {20'd0, v};
    bus.mbREAD   = 1'b1;
    bus.mbWRITE  = 1'b1;
    tick();
    bus.mbREAD   = 1'b0;
    bus.mbWRITE  = 1'b0;
    check("rw_same_old", 36'(bus.mbREGDAT), 36'(old));
    m_da = v;
    reg_rd(5'd5, m_da, "rw_same_new");

    da_wr(16'd5);
    drv_go(5'd2);
    check("seek_dry0", 36'(bus.mbDRY), 36'd0);
    wait_seek(1'b1, "seek");
    reg_rd(5'd1, exp_ds(), "ds_seek_done");
    check("ds_seek_const", 36'(exp_ds()), 36'o110600);
    reg_rd(5'd0, 16'((m_dry ? 128 : 0) + 2 * m_fun), "cs1_seek");
    reg_rd(5'd4, 16'd1, "as_ata");
    reg_wr(5'd4, 16'd1, 1'b0, 5'd0);
    m_ata = 0;
    check("as_clear", 36'(bus.mbATA), 36'd0);

    da_wr(16'o777);
    drv_go(5'd3);
    wait_seek(1'b1, "recal");
    reg_rd(5'd5, m_da, "recal_da");
    reg_wr(5'd4, 16'd1, 1'b0, 5'd0);
    m_ata = 0;

    da_wr(16'd5);
    xfer(1'b0, 3, 0, "rd_fixed");
    for (int r = 0; r < 3; r++) begin
      da_wr(16'($urandom));
      nw = $urandom_range(1, 5);
      xfer(1'b0, nw, 2, "rd_rand");
    end

    wdat[0] = 16'o177777;
    wdat[1] = 16'o000002;
    xfer(1'b1, 2, 0, "wr_fixed");
    reg_rd(5'd7, exp_ck(), "ck_fixed");
    nw = $urandom_range(1, 6);
    for (int i = 0; i < nw; i++) wdat[i] = 16'($urandom);
    xfer(1'b1, nw, 2, "wr_rand");
    reg_rd(5'd7, exp_ck(), "ck_rand");

    drv_go(5'd2);
    reg_rd(5'd1, exp_ds(), "ds_pip");
    da_wr(16'h1234);
    reg_rd(5'd2, exp_er1(), "er1_da_busy");
    check("ata_da_busy", 36'(bus.mbATA), 36'(m_ata));
    drv_go(5'd0);
    check("ata_go_busy", 36'(bus.mbATA), 36'(m_ata));
    reg_rd(5'd2, exp_er1(), "er1_rmr");
    wait_seek(1'b0, "seek2");
    reg_rd(5'd5, m_da, "da_kept");
    drv_go(5'd4);
    reg_rd(5'd2, exp_er1(), "er1_clr");
    reg_rd(5'd7, exp_ck(), "ck_clr");
    check("ata_clr", 36'(bus.mbATA), 36'(m_ata));
    drv_go(5'd7);
    reg_rd(5'd2, exp_er1(), "er1_ilf");
    reg_rd(5'd1, exp_ds(), "ds_ilf");
    check("ata_ilf", 36'(bus.mbATA), 36'(m_ata));
    drv_go(5'd4);
    reg_rd(5'd2, exp_er1(), "er1_clr2");

    da_wr(16'd9);
    drv_go(5'd28);
    check("init_reqo_pre", 36'(bus.mbREQO), 36'd1);
    bus.mbINIT = 1'b1;
    tick();
    bus.mbINIT = 1'b0;
    model_reset();
    check("init_reqo", 36'(bus.mbREQO), 36'd0);
    check("init_npro", 36'(bus.mbNPRO), 36'd0);
    check("init_dry", 36'(bus.mbDRY), 36'd1);
    check("init_incba", 36'(bus.mbINCBA), 36'd0);
    tick();
    check("init_incwc", 36'(bus.mbINCWC), 36'd0);
    reg_rd(5'd5, m_da, "init_da");

    bus.mbUNIT   = 3'd5;
    bus.mbREGSEL = 5'd1;
    bus.mbREAD   = 1'b1;
    #1;
    check("dpr_other", 36'(bus.mbDPR), 36'd0);
    tick();
    bus.mbREAD   = 1'b0;
    check("other_ack", 36'(bus.mbREGACK), 36'd0);
    check("other_dat", 36'(bus.mbREGDAT), 36'd0);
    bus.mbUNIT   = 3'd0;
    #1;
    check("dpr_self", 36'(bus.mbDPR), 36'd1);

    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
